// File: rtl/median_win_fetch.sv
// 3x3 window fetcher: reads a centre pixel's neighbourhood from frame RAM and hands it to the sorter.
// Build option WIN_ZERO_PAD_EN: zero-pad out-of-image neighbours instead of edge-replicating them.
module median_win_fetch #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned DIM_W  = 10,
  parameter int unsigned ADDR_W = 18
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 pix_done_sig,
  input  logic [DIM_W-1:0]     row_addr_sig,
  input  logic [DIM_W-1:0]     column_addr_sig,
  input  logic [DIM_W-1:0]     rows,
  input  logic [DIM_W-1:0]     cols,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [PIX_W-1:0]     rd_data,
  output logic [9*PIX_W-1:0]   win_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 nxt_pix_sig,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int unsigned DW1 = DIM_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StValid,
    StNext,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [DIM_W-1:0]   row_q, col_q, rows_q, cols_q;
  logic               cap_vld_q, cap_zero_q;
  logic [3:0]         cap_k_q;
  logic [PIX_W-1:0]   win_q [9];

  logic               start;
  logic [1:0]         ri, ci;
  logic [DIM_W:0]     r_sum, c_sum;
  logic               r_lo, r_hi, c_lo, c_hi;
  logic [DIM_W-1:0]   r_cl, c_cl;
  logic [ADDR_W-1:0]  addr;
  logic               slot_zero;
  logic               in_read;

  assign start   = pix_done_sig && (row_addr_sig != '0) && (column_addr_sig != '0);
  assign in_read = (state_q == StRead);

  // Slot k maps to row offset k/3 and column offset k%3 (both biased by +1).
  always_comb begin
    ri = 2'd0;
    ci = 2'd0;
    case (k_q)
      4'd0:    begin ri = 2'd0; ci = 2'd0; end
      4'd1:    begin ri = 2'd0; ci = 2'd1; end
      4'd2:    begin ri = 2'd0; ci = 2'd2; end
      4'd3:    begin ri = 2'd1; ci = 2'd0; end
      4'd4:    begin ri = 2'd1; ci = 2'd1; end
      4'd5:    begin ri = 2'd1; ci = 2'd2; end
      4'd6:    begin ri = 2'd2; ci = 2'd0; end
      4'd7:    begin ri = 2'd2; ci = 2'd1; end
      4'd8:    begin ri = 2'd2; ci = 2'd2; end
      default: begin ri = 2'd0; ci = 2'd0; end
    endcase
  end

  // Latched row/col are always >= 1, so the biased sums never wrap below zero.
  always_comb begin
    r_sum = {1'b0, row_q} + DW1'(ri) - DW1'(1);
    c_sum = {1'b0, col_q} + DW1'(ci) - DW1'(1);
    r_lo  = (r_sum == '0);
    r_hi  = (r_sum > {1'b0, rows_q});
    c_lo  = (c_sum == '0);
    c_hi  = (c_sum > {1'b0, cols_q});
    if (r_lo) begin
      r_cl = DIM_W'(1);
    end else if (r_hi) begin
      r_cl = rows_q;
    end else begin
      r_cl = r_sum[DIM_W-1:0];
    end
    if (c_lo) begin
      c_cl = DIM_W'(1);
    end else if (c_hi) begin
      c_cl = cols_q;
    end else begin
      c_cl = c_sum[DIM_W-1:0];
    end
    addr = ADDR_W'(r_cl - DIM_W'(1)) * ADDR_W'(cols_q) + ADDR_W'(c_cl - DIM_W'(1));
  end

`ifdef WIN_ZERO_PAD_EN
  assign slot_zero = r_lo | r_hi | c_lo | c_hi;
`else
  assign slot_zero = 1'b0;
`endif

  always_comb begin
    rd_en   = in_read && !slot_zero;
    rd_addr = rd_en ? addr : '0;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          k_d     = '0;
        end
      end
      StRead: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd8) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StValid;
      StValid: begin
        if (win_ready) begin
          state_d = ((row_q == rows_q) && (col_q == cols_q)) ? StDone : StNext;
        end
      end
      StNext:  state_d = StIdle;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      k_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      cap_vld_q  <= 1'b0;
      cap_zero_q <= 1'b0;
      cap_k_q    <= '0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if ((state_q == StIdle) && start) begin
        row_q  <= row_addr_sig;
        col_q  <= column_addr_sig;
        rows_q <= rows;
        cols_q <= cols;
      end
      // RAM data lags rd_en by one cycle, so the slot tag is pipelined alongside it.
      cap_vld_q  <= in_read;
      cap_zero_q <= slot_zero;
      cap_k_q    <= k_q;
      if (cap_vld_q) begin
        win_q[cap_k_q] <= cap_zero_q ? '0 : rd_data;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < 9; i++) begin
      win_data[i*PIX_W +: PIX_W] = win_q[i];
    end
  end

  assign win_valid   = (state_q == StValid);
  assign nxt_pix_sig = (state_q == StNext);
  assign frame_done  = (state_q == StDone);
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_median_win_fetch.sv
// Directed bench for median_win_fetch with a behavioural frame RAM holding RAM[i] = i + 16.
module tb_median_win_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pix_done_sig;
  logic [9:0]  row_addr_sig, column_addr_sig, rows, cols;
  logic        rd_en;
  logic [17:0] rd_addr;
  logic [7:0]  rd_data;
  logic [71:0] win_data;
  logic        win_valid, win_ready, nxt_pix_sig, frame_done, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_addr [9];
  bit exp_en   [9];

  median_win_fetch dut (
    .CLK             (CLK),
    .RST             (RST),
    .pix_done_sig    (pix_done_sig),
    .row_addr_sig    (row_addr_sig),
    .column_addr_sig (column_addr_sig),
    .rows            (rows),
    .cols            (cols),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .win_data        (win_data),
    .win_valid       (win_valid),
    .win_ready       (win_ready),
    .nxt_pix_sig     (nxt_pix_sig),
    .frame_done      (frame_done),
    .busy            (busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] pix_of(input int a);
    return 8'(a + 16);
  endfunction

  always @(posedge CLK) begin
    if (rd_en) rd_data <= pix_of(int'(rd_addr));
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called at #1 after an edge with the DUT idle; returns idle one cycle after the handoff pulse.
  task automatic run_window(input int r, input int c, input int stall, input bit last);
    logic [71:0] exp_win;
    exp_win = '0;
    for (int s = 0; s < 9; s++) begin
      if (exp_en[s]) exp_win[s*8 +: 8] = pix_of(exp_addr[s]);
    end
    pix_done_sig    = 1'b1;
    row_addr_sig    = 10'(r);
    column_addr_sig = 10'(c);
    win_ready       = (stall == 0);
    step();
    pix_done_sig    = 1'b0;
    row_addr_sig    = '0;
    column_addr_sig = '0;
    check_eq($sformatf("busy_read(%0d,%0d)", r, c), busy, 1'b1);
    for (int s = 0; s < 9; s++) begin
      check_eq($sformatf("rd_en(%0d,%0d)[%0d]", r, c, s), rd_en, exp_en[s]);
      check_eq($sformatf("rd_addr(%0d,%0d)[%0d]", r, c, s), rd_addr, exp_addr[s]);
      step();
    end
    check_eq("drain_valid", win_valid, 1'b0);
    check_eq("drain_rd_en", rd_en, 1'b0);
    step();
    check_eq($sformatf("valid(%0d,%0d)", r, c), win_valid, 1'b1);
    check_eq($sformatf("win(%0d,%0d)", r, c), win_data, exp_win);
    if (stall > 0) begin
      for (int i = 1; i < stall; i++) begin
        step();
        check_eq($sformatf("stall_valid[%0d]", i), win_valid, 1'b1);
        check_eq($sformatf("stall_win[%0d]", i), win_data, exp_win);
        check_eq($sformatf("stall_nxt[%0d]", i), nxt_pix_sig, 1'b0);
      end
      step();
      win_ready = 1'b1;
      check_eq("accept_valid", win_valid, 1'b1);
      check_eq("accept_win", win_data, exp_win);
    end
    step();
    win_ready = 1'b0;
    check_eq("post_valid", win_valid, 1'b0);
    check_eq("post_nxt", nxt_pix_sig, !last);
    check_eq("post_done", frame_done, last);
    check_eq("post_busy", busy, 1'b1);
    step();
    check_eq("idle_nxt", nxt_pix_sig, 1'b0);
    check_eq("idle_done", frame_done, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
  endtask

  initial begin
    RST             = 1'b1;
    pix_done_sig    = 1'b0;
    row_addr_sig    = '0;
    column_addr_sig = '0;
    rows            = 10'd3;
    cols            = 10'd4;
    win_ready       = 1'b0;
    step();
    step();
    check_eq("rst_rd_en", rd_en, 1'b0);
    check_eq("rst_rd_addr", rd_addr, 18'd0);
    check_eq("rst_win", win_data, 72'd0);
    check_eq("rst_valid", win_valid, 1'b0);
    check_eq("rst_nxt", nxt_pix_sig, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    RST = 1'b0;
    step();

    // Strobe with a zero column must be ignored.
    pix_done_sig    = 1'b1;
    row_addr_sig    = 10'd2;
    column_addr_sig = 10'd0;
    step();
    pix_done_sig = 1'b0;
    check_eq("ignore_busy", busy, 1'b0);
    check_eq("ignore_rd_en", rd_en, 1'b0);

    // Interior centre with 5 cycles of sorter backpressure.
    exp_addr = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    exp_en   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_window(2, 2, 5, 1'b0);

    // Top-left corner, sorter already ready.
`ifdef WIN_ZERO_PAD_EN
    exp_addr = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
    exp_en   = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
`else
    exp_addr = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
    exp_en   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    run_window(1, 1, 0, 1'b0);

    // Last centre of the frame ends with frame_done instead of nxt_pix_sig.
`ifdef WIN_ZERO_PAD_EN
    exp_addr = '{6, 7, 0, 10, 11, 0, 0, 0, 0};
    exp_en   = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
`else
    exp_addr = '{6, 7, 7, 10, 11, 11, 10, 11, 11};
    exp_en   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    run_window(3, 4, 2, 1'b1);

    // Reset in the middle of READ aborts silently.
    pix_done_sig    = 1'b1;
    row_addr_sig    = 10'd2;
    column_addr_sig = 10'd2;
    step();
    pix_done_sig = 1'b0;
    step();
    step();
    step();
    check_eq("pre_rst_rd_en", rd_en, 1'b1);
    check_eq("pre_rst_rd_addr", rd_addr, 18'd4);
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_eq("mid_rst_rd_en", rd_en, 1'b0);
    check_eq("mid_rst_rd_addr", rd_addr, 18'd0);
    check_eq("mid_rst_win", win_data, 72'd0);
    check_eq("mid_rst_valid", win_valid, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("after_rst_nxt[%0d]", i), nxt_pix_sig, 1'b0);
      check_eq($sformatf("after_rst_done[%0d]", i), frame_done, 1'b0);
      check_eq($sformatf("after_rst_busy[%0d]", i), busy, 1'b0);
    end

    // Clean window after the abort.
    exp_addr = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    exp_en   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_window(2, 3, 1, 1'b0);

    // Degenerate 1x1 frame.
    rows = 10'd1;
    cols = 10'd1;
`ifdef WIN_ZERO_PAD_EN
    exp_addr = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_en   = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
`else
    exp_addr = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_en   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    run_window(1, 1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
